mux_scan_collector: RTL and testbench
=====================================

MUX_SCAN_COLLECTOR -- requirements
Module: mux_scan_collector

Interface
REQ-001 Parameter SETTLE, default 1: wait cycles after each select change before sampling; legal range 0..7.
REQ-002 Parameter CONTINUOUS, default 0: 1 = restart the scan automatically after each frame handshake.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request one 16-channel scan; sampled only in IDLE or at the HOLD handshake.
REQ-006 mux_out  input  2  selected channel data returned by the downstream 16:1 mux.
REQ-007 select  output  4  channel index driven to the mux select, registered.
REQ-008 frame  output  32  assembled frame; channel k occupies bits [2k+1:2k].
REQ-009 frame_valid  output  1  frame holds a complete, stable scan result.
REQ-010 frame_ready  input  1  consumer accepts frame; handshake when frame_valid and frame_ready are both 1.
REQ-011 busy  output  1  high in SETTLE, SAMPLE and HOLD.
REQ-012 overrun  output  1  sticky; set when start=1 arrives while busy and is not consumed as a restart.

Function
REQ-013 States SHALL be IDLE, SETTLE, SAMPLE and HOLD.
REQ-014 IDLE: on start=1, select SHALL be set to 0 and the state SHALL go to SETTLE; if SETTLE=0, the state SHALL go directly to SAMPLE.
REQ-015 SETTLE: the state SHALL remain for exactly SETTLE cycles with select constant, then go to SAMPLE.
REQ-016 SAMPLE (one cycle): mux_out SHALL be written into capture-buffer bits [2*select+1:2*select].
REQ-017 In SAMPLE with select<15: select SHALL increment, and the state SHALL go to SETTLE (or to SAMPLE if SETTLE=0).
REQ-018 In SAMPLE with select=15: the frame register SHALL load the completed buffer, including the current sample, and the state SHALL go to HOLD.
REQ-019 select SHALL NOT wrap past 15 within a scan; select SHALL return to 0 only at scan start.
REQ-020 HOLD: frame_valid=1, and frame SHALL be stable until the handshake.
REQ-021 On handshake in HOLD: frame_valid SHALL drop next cycle.
REQ-022 After a handshake in HOLD, a new scan SHALL begin (select=0) if CONTINUOUS=1 or start=1 in the handshake cycle; otherwise the state SHALL go to IDLE.
REQ-023 Latency: frame_valid SHALL rise exactly 16*(SETTLE+1)+1 cycles after the cycle in which start is accepted.
REQ-024 The frame output SHALL keep the last delivered value through IDLE and through the next scan, until the next completed scan loads it.
REQ-025 start=1 in SETTLE, SAMPLE, or in HOLD without a handshake SHALL be ignored and SHALL set overrun.
REQ-026 frame_ready while not in HOLD SHALL be ignored.

Reset
REQ-027 While rst=1 at a clock edge, the following SHALL be cleared: state=IDLE, select=0, frame=0, capture buffer=0, frame_valid=0, busy=0, overrun=0, settle counter=0.
REQ-028 rst mid-scan or in HOLD SHALL abort immediately and discard any pending frame; start is ignored in the reset cycle.
REQ-029 overrun SHALL clear only on rst.

Structure
REQ-030 The shared package SHALL hold the state enum, NUM_CH=16, CH_W=2, SEL_W=4 and FRAME_W=NUM_CH*CH_W.
REQ-031 The settle down-counter SHALL be a sub-module, settle_timer, with load/count/done ports.
REQ-032 The capture buffer and frame register SHALL be separate registers.

Verification
REQ-033 The bench SHALL drive mux_out from a behavioural 16:1 mux with in_k = k mod 4, SETTLE=1, and pulse start -> frame=32'hE4E4E4E4, with frame_valid rising 33 cycles after the start cycle.
REQ-034 With SETTLE=0, start, and the same mux model -> select steps 0..15 on consecutive cycles, and frame_valid rises 17 cycles after the start cycle.
REQ-035 frame_ready held 0 for 10 cycles in HOLD, then 1 -> frame unchanged and frame_valid=1 throughout, frame_valid=0 the cycle after the handshake, and the state goes to IDLE.
REQ-036 start pulsed at select=5 mid-scan -> scan unaffected, overrun=1, and overrun stays 1 after the next frame.
REQ-037 CONTINUOUS=1, with mux in_k changed to 3 after the first handshake -> second frame=32'hFFFFFFFF, and select restarts at 0 the cycle after the handshake.
REQ-038 rst asserted at select=9 -> next cycle all outputs are zero and the state is IDLE; a following start produces a correct full frame.

Source files
------------

// File: rtl/mux_scan_collector_pkg.sv
// Shared types and sizes for the mux scan collector: state encoding,
// channel geometry and the helper that drops one sample into a frame image.
package mux_scan_collector_pkg;

  localparam int NUM_CH  = 16;
  localparam int CH_W    = 2;
  localparam int SEL_W   = 4;
  localparam int FRAME_W = NUM_CH * CH_W;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  function automatic logic [FRAME_W-1:0] insert_sample(
    input logic [FRAME_W-1:0] buf_in,
    input logic [SEL_W-1:0]   sel,
    input logic [CH_W-1:0]    data
  );
    logic [FRAME_W-1:0] f;
    f = buf_in;
    f[int'(sel) * CH_W +: CH_W] = data;
    return f;
  endfunction

endpackage

// File: rtl/mux_scan_collector_if.sv
// Bus between the scan collector, the downstream 16:1 mux and the frame consumer.
interface mux_scan_collector_if;
  import mux_scan_collector_pkg::*;

  logic               start;
  logic [CH_W-1:0]    mux_out;
  logic [SEL_W-1:0]   select;
  logic [FRAME_W-1:0] frame;
  logic               frame_valid;
  logic               frame_ready;
  logic               busy;
  logic               overrun;

  modport slave (
    input  start, mux_out, frame_ready,
    output select, frame, frame_valid, busy, overrun
  );

  modport master (
    output start, mux_out, frame_ready,
    input  select, frame, frame_valid, busy, overrun
  );

endinterface

// File: rtl/mux_scan_collector_settle_timer.sv
// Settle down-counter: loaded on entry to a settle window, counted down while
// settling; done marks the final cycle of the window.
module settle_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             count,
  output logic             done
);

  logic [CNT_W-1:0] cnt_r;

  // Down-counter that stops at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (count && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == CNT_W'(1));

endmodule

// File: rtl/mux_scan_collector.sv
// Scans a 16:1 mux channel by channel, packs the 2-bit samples into a frame
// and offers the frame to a consumer with a valid/ready handshake.
module mux_scan_collector
  import mux_scan_collector_pkg::*;
#(
  parameter int SETTLE     = 1,
  parameter bit CONTINUOUS = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  mux_scan_collector_if.slave bus
);

  localparam bit         HAS_SETTLE = (SETTLE != 0);
  localparam logic [2:0] SETTLE_VAL = 3'(SETTLE);

  state_t             state_r;
  logic [SEL_W-1:0]   select_r;
  logic [FRAME_W-1:0] cap_r;
  logic [FRAME_W-1:0] frame_r;
  logic               frame_valid_r;
  logic               busy_r;
  logic               overrun_r;

  logic               handshake_s;
  logic               last_s;
  logic               scan_begin_s;
  logic               load_s;
  logic               count_s;
  logic               settle_done_s;
  logic               overrun_hit_s;
  logic [FRAME_W-1:0] cap_next_s;
  state_t             scan_state_s;

  // Decode handshake, scan starts, settle-timer control and overrun events
  always_comb begin
    handshake_s   = (state_r == ST_HOLD) && bus.frame_ready;
    last_s        = (select_r == LAST_SEL);
    scan_begin_s  = ((state_r == ST_IDLE) && bus.start) ||
                    (handshake_s && (CONTINUOUS || bus.start));
    cap_next_s    = insert_sample(cap_r, select_r, bus.mux_out);
    load_s        = HAS_SETTLE && (scan_begin_s || ((state_r == ST_SAMPLE) && !last_s));
    count_s       = (state_r == ST_SETTLE);
    overrun_hit_s = bus.start &&
                    ((state_r == ST_SETTLE) || (state_r == ST_SAMPLE) ||
                     ((state_r == ST_HOLD) && !handshake_s));
    // With no settle time every channel is sampled on consecutive cycles
    if (HAS_SETTLE) begin
      scan_state_s = ST_SETTLE;
    end else begin
      scan_state_s = ST_SAMPLE;
    end
  end

  settle_timer #(
    .CNT_W (3)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (SETTLE_VAL),
    .count    (count_s),
    .done     (settle_done_s)
  );

  // Scan state machine with registered select, buffers and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      select_r      <= {SEL_W{1'b0}};
      cap_r         <= {FRAME_W{1'b0}};
      frame_r       <= {FRAME_W{1'b0}};
      frame_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      overrun_r <= overrun_r | overrun_hit_s;
      case (state_r)
        ST_IDLE: begin
          if (scan_begin_s) begin
            select_r <= {SEL_W{1'b0}};
            state_r  <= scan_state_s;
            busy_r   <= 1'b1;
          end else begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (settle_done_s) begin
            state_r <= ST_SAMPLE;
          end else begin
            state_r <= ST_SETTLE;
          end
        end
        ST_SAMPLE: begin
          cap_r <= cap_next_s;
          // The last channel goes straight into the frame alongside the buffer
          if (last_s) begin
            frame_r       <= cap_next_s;
            frame_valid_r <= 1'b1;
            state_r       <= ST_HOLD;
          end else begin
            select_r <= select_r + SEL_W'(1);
            state_r  <= scan_state_s;
          end
        end
        ST_HOLD: begin
          if (handshake_s) begin
            frame_valid_r <= 1'b0;
            if (scan_begin_s) begin
              select_r <= {SEL_W{1'b0}};
              state_r  <= scan_state_s;
            end else begin
              state_r  <= ST_IDLE;
              busy_r   <= 1'b0;
            end
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          frame_valid_r <= 1'b0;
          busy_r        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.select      = select_r;
  assign bus.frame       = frame_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.busy        = busy_r;
  assign bus.overrun     = overrun_r;

endmodule

// File: tb/tb_mux_scan_collector.sv
// Scoreboard bench: three collectors (SETTLE 1/0/2, the last one CONTINUOUS)
// fed by behavioural 16:1 muxes; expected frames and due cycles are queued.
module tb_mux_scan_collector;
  import mux_scan_collector_pkg::*;

  localparam int N  = 3;
  localparam int S0 = 1;
  localparam int S1 = 0;
  localparam int S2 = 2;

  typedef struct {
    logic [31:0] frame;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        start_d [N];
  logic        ready_d [N];
  logic [1:0]  in_vals [N][16];
  logic [3:0]  sel_m   [N];
  logic [31:0] frame_m [N];
  logic        fv_m    [N];
  logic        busy_m  [N];
  logic        ovr_m   [N];

  exp_t        exp_q [N][$];
  exp_t        mon_e;
  logic        prev_fv [N];
  logic        prev_hs [N];
  logic [31:0] held    [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int S = (g == 0) ? S0 : ((g == 1) ? S1 : S2);
    localparam bit C = (g == 2);
    mux_scan_collector_if bus ();
    assign bus.start       = start_d[g];
    assign bus.frame_ready = ready_d[g];
    assign bus.mux_out     = in_vals[g][bus.select];
    assign sel_m[g]        = bus.select;
    assign frame_m[g]      = bus.frame;
    assign fv_m[g]         = bus.frame_valid;
    assign busy_m[g]       = bus.busy;
    assign ovr_m[g]        = bus.overrun;
    mux_scan_collector #(.SETTLE(S), .CONTINUOUS(C)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  function automatic int lat_of(input int i);
    int s;
    if (i == 0) s = S0;
    else if (i == 1) s = S1;
    else s = S2;
    return 16 * (s + 1) + 1;
  endfunction

  // Reference frame: channel k's mux input sits at bits [2k+1:2k]
  function automatic logic [31:0] model_frame(input int i);
    logic [31:0] f;
    f = 32'd0;
    for (int k = 0; k < 16; k++) f = f | (32'(in_vals[i][k]) << (2 * k));
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int i, input logic [31:0] f, input int due);
    exp_t e;
    e.frame = f;
    e.due   = due;
    exp_q[i].push_back(e);
  endtask

  task automatic rand_vals(input int i);
    for (int k = 0; k < 16; k++) in_vals[i][k] = 2'($urandom_range(0, 3));
  endtask

  task automatic ramp_vals(input int i);
    for (int k = 0; k < 16; k++) in_vals[i][k] = 2'(k % 4);
  endtask

  task automatic start_pulse(input int i, input logic [31:0] f);
    push_exp(i, f, cyc + lat_of(i));
    start_d[i] = 1'b1;
    tick();
    start_d[i] = 1'b0;
  endtask

  task automatic handshake(input int i, input bit with_start, output int h);
    h = cyc;
    ready_d[i] = 1'b1;
    start_d[i] = with_start;
    tick();
    ready_d[i] = 1'b0;
    start_d[i] = 1'b0;
  endtask

  task automatic wait_fv(input int i, input int budget);
    int n;
    n = 0;
    while (fv_m[i] !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("wait_fv%0d", i), 32'(fv_m[i]), 32'd1);
  endtask

  task automatic wait_sel(input int i, input logic [3:0] v, input int budget);
    int n;
    n = 0;
    while (sel_m[i] !== v && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("wait_sel%0d", i), 32'(sel_m[i]), 32'(v));
  endtask

  task automatic chk_zero(input int i);
    chk($sformatf("rst_sel%0d", i), 32'(sel_m[i]), 32'd0);
    chk($sformatf("rst_frame%0d", i), frame_m[i], 32'd0);
    chk($sformatf("rst_fv%0d", i), 32'(fv_m[i]), 32'd0);
    chk($sformatf("rst_busy%0d", i), 32'(busy_m[i]), 32'd0);
    chk($sformatf("rst_ovr%0d", i), 32'(ovr_m[i]), 32'd0);
  endtask

  // Monitor: pops on each frame_valid rise, checks stability and the drop after handshake
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        prev_fv[i] = 1'b0;
        prev_hs[i] = 1'b0;
      end else begin
        if (prev_hs[i]) begin
          chk($sformatf("fv_drop%0d", i), 32'(fv_m[i]), 32'd0);
        end else if (fv_m[i] && prev_fv[i]) begin
          chk($sformatf("frame_stable%0d", i), frame_m[i], held[i]);
        end else if (fv_m[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame%0d: got %h expected no frame", i, frame_m[i]);
          end else begin
            mon_e = exp_q[i].pop_front();
            chk($sformatf("frame%0d", i), frame_m[i], mon_e.frame);
            chk($sformatf("latency%0d", i), 32'(cyc), 32'(mon_e.due));
          end
        end
        prev_fv[i] = fv_m[i];
        prev_hs[i] = fv_m[i] && ready_d[i];
        held[i]    = frame_m[i];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int h;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      start_d[i] = 1'b0;
      ready_d[i] = 1'b0;
      for (int k = 0; k < 16; k++) in_vals[i][k] = 2'd0;
    end
    repeat (3) tick();
    for (int i = 0; i < N; i++) chk_zero(i);
    rst = 1'b0;
    tick();

    // SETTLE=0: select walks 0..15 on consecutive cycles
    ramp_vals(1);
    start_pulse(1, 32'hE4E4E4E4);
    for (int k = 0; k < 16; k++) begin
      chk("sel_step1", 32'(sel_m[1]), 32'(k));
      tick();
    end
    wait_fv(1, 5);
    handshake(1, 1'b0, h);
    chk("idle_busy1", 32'(busy_m[1]), 32'd0);

    // SETTLE=1 ramp frame, then consumer stalls for 10 cycles
    ramp_vals(0);
    start_pulse(0, 32'hE4E4E4E4);
    wait_fv(0, 40);
    for (int k = 0; k < 10; k++) begin
      chk("hold_fv0", 32'(fv_m[0]), 32'd1);
      chk("hold_frame0", frame_m[0], 32'hE4E4E4E4);
      tick();
    end
    handshake(0, 1'b0, h);
    chk("post_fv0", 32'(fv_m[0]), 32'd0);
    chk("post_busy0", 32'(busy_m[0]), 32'd0);
    chk("post_sel0", 32'(sel_m[0]), 32'd15);
    chk("idle_frame0", frame_m[0], 32'hE4E4E4E4);

    // Start while mid-scan is ignored but flagged
    rand_vals(0);
    start_pulse(0, model_frame(0));
    wait_sel(0, 4'd5, 40);
    start_d[0] = 1'b1;
    tick();
    start_d[0] = 1'b0;
    chk("ovr_set0", 32'(ovr_m[0]), 32'd1);
    wait_fv(0, 40);
    handshake(0, 1'b0, h);
    chk("ovr_sticky0", 32'(ovr_m[0]), 32'd1);
    chk("ovr_idle0", 32'(busy_m[0]), 32'd0);

    // CONTINUOUS restart after handshake, mux inputs switched to 3
    ramp_vals(2);
    start_pulse(2, 32'hE4E4E4E4);
    wait_fv(2, 60);
    handshake(2, 1'b0, h);
    chk("cont_sel2", 32'(sel_m[2]), 32'd0);
    chk("cont_busy2", 32'(busy_m[2]), 32'd1);
    for (int k = 0; k < 16; k++) in_vals[2][k] = 2'd3;
    push_exp(2, 32'hFFFFFFFF, h + lat_of(2));
    wait_fv(2, 60);

    // Reset mid-scan aborts everything; start in reset cycle ignored
    rand_vals(0);
    start_pulse(0, model_frame(0));
    wait_sel(0, 4'd9, 40);
    rst = 1'b1;
    start_d[1] = 1'b1;
    for (int i = 0; i < N; i++) exp_q[i].delete();
    tick();
    rst = 1'b0;
    start_d[1] = 1'b0;
    for (int i = 0; i < N; i++) chk_zero(i);
    rand_vals(0);
    start_pulse(0, model_frame(0));
    wait_fv(0, 40);
    handshake(0, 1'b0, h);

    // Random scans with random consumer delay and back-to-back restarts
    for (int it = 0; it < 8; it++) begin
      int i;
      i = int'($urandom_range(0, 1));
      rand_vals(i);
      start_pulse(i, model_frame(i));
      wait_fv(i, 40);
      repeat ($urandom_range(0, 4)) tick();
      if ($urandom_range(0, 1) == 1) begin
        rand_vals(i);
        handshake(i, 1'b1, h);
        push_exp(i, model_frame(i), h + lat_of(i));
        wait_fv(i, 40);
      end
      handshake(i, 1'b0, h);
      chk("rand_idle", 32'(busy_m[i]), 32'd0);
    end

    tick();
    for (int i = 0; i < N; i++) chk($sformatf("queue_empty%0d", i), 32'(exp_q[i].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
